// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encodings and a
// ceiling-log2 helper used to size iteration counters.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic             overflow;

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow_out, overflow
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow_out, overflow
   );
endinterface

// File: rtl/serial_subtractor_one_bit_full_subtractor.sv
// One-bit full subtractor (a - b - bin) built from two half subtractors and an OR.
module one_bit_full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   logic d1, b1, b2;

   assign d1   = a ^ b;
   assign b1   = ~a & b;
   assign d    = d1 ^ bin;
   assign b2   = ~d1 & bin;
   assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock LSB first, using a
// single full subtractor and a borrow flip-flop; one result per WIDTH+2 cycles.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_subtractor_if.slave bus
);
   localparam int CNT_W = clog2(WIDTH) + 1;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [WIDTH-1:0] diff_q;
   logic [CNT_W-1:0] cnt;
   logic             a_msb;
   logic             b_msb;
   logic             borrow;
   logic             busy_q;
   logic             done_q;
   logic             borrow_q;
   logic             ovf_q;
   logic             d_bit;
   logic             bout_bit;

   one_bit_full_subtractor u_fs (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (borrow),
      .d    (d_bit),
      .bout (bout_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         a_sh     <= '0;
         b_sh     <= '0;
         res_sh   <= '0;
         diff_q   <= '0;
         cnt      <= '0;
         a_msb    <= 1'b0;
         b_msb    <= 1'b0;
         borrow   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_sh   <= bus.a;
                  b_sh   <= bus.b;
                  a_msb  <= bus.a[WIDTH-1];
                  b_msb  <= bus.b[WIDTH-1];
                  borrow <= 1'b0;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               res_sh <= {d_bit, res_sh[WIDTH-1:1]};
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               borrow <= bout_bit;
               cnt    <= cnt + 1'b1;
               // Final bit: publish the result in the same edge that enters DONE
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  diff_q   <= {d_bit, res_sh[WIDTH-1:1]};
                  borrow_q <= bout_bit;
                  ovf_q    <= (a_msb != b_msb) && (d_bit != a_msb);
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state    <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_q <= 1'b0;
               state  <= ST_IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               done_q <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.diff       = diff_q;
   assign bus.borrow_out = borrow_q;
   assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=16 against a
// cycle-timed arithmetic reference model.
module tb_serial_subtractor;
   logic clk;
   logic rst_n;
   int   errs;
   int   checks;
   int   cyc;

   serial_subtractor_if #(.WIDTH(8))  if8 ();
   serial_subtractor_if #(.WIDTH(16)) if16 ();

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if8)
   );

   serial_subtractor #(.WIDTH(16)) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic: modular difference, unsigned borrow, signed range overflow
   function automatic void calc(input int w, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] d, output bit bo, output bit ov);
      logic [63:0] mask;
      longint sa, sb, r, mx, mn;
      mask = (64'd1 << w) - 64'd1;
      d    = (a - b) & mask;
      bo   = (a < b);
      sa   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
      sb   = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
      r    = sa - sb;
      mx   = (longint'(1) << (w - 1)) - 1;
      mn   = -(longint'(1) << (w - 1));
      ov   = (r > mx) || (r < mn);
   endfunction

   // Model: t=0 idle, 1..W in progress, W+1 done pulse
   logic [63:0] m8_a, m8_b, e8_diff, m16_a, m16_b, e16_diff;
   bit          e8_bo, e8_ov, e16_bo, e16_ov;
   int          m8_t, m16_t;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m8_t = 0; e8_diff = '0; e8_bo = 0; e8_ov = 0;
      end else if (m8_t == 0) begin
         if (if8.start) begin
            m8_a = 64'(if8.a); m8_b = 64'(if8.b); m8_t = 1;
         end
      end else if (m8_t <= 8) begin
         m8_t++;
         if (m8_t == 9) calc(8, m8_a, m8_b, e8_diff, e8_bo, e8_ov);
      end else begin
         m8_t = 0;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m16_t = 0; e16_diff = '0; e16_bo = 0; e16_ov = 0;
      end else if (m16_t == 0) begin
         if (if16.start) begin
            m16_a = 64'(if16.a); m16_b = 64'(if16.b); m16_t = 1;
         end
      end else if (m16_t <= 16) begin
         m16_t++;
         if (m16_t == 17) calc(16, m16_a, m16_b, e16_diff, e16_bo, e16_ov);
      end else begin
         m16_t = 0;
      end
   end

   always @(negedge clk) begin
      chk("busy8", 64'(if8.busy), 64'(m8_t >= 1 && m8_t <= 8));
      chk("done8", 64'(if8.done), 64'(m8_t == 9));
      chk("diff8", 64'(if8.diff), e8_diff);
      chk("borrow8", 64'(if8.borrow_out), 64'(e8_bo));
      chk("ovf8", 64'(if8.overflow), 64'(e8_ov));
      chk("busy16", 64'(if16.busy), 64'(m16_t >= 1 && m16_t <= 16));
      chk("done16", 64'(if16.done), 64'(m16_t == 17));
      chk("diff16", 64'(if16.diff), e16_diff);
      chk("borrow16", 64'(if16.borrow_out), 64'(e16_bo));
      chk("ovf16", 64'(if16.overflow), 64'(e16_ov));
   end

   // Pulses start for one cycle on dut8; reports busy cycles before done
   task automatic op8(input logic [7:0] a, input logic [7:0] b, output int nbusy, output bit seen);
      @(negedge clk);
      if8.a = a; if8.b = b; if8.start = 1'b1;
      @(negedge clk);
      if8.start = 1'b0;
      if8.a = ~a; if8.b = ~b;
      nbusy = 0; seen = 0;
      for (int i = 0; i < 30; i++) begin
         if (if8.done) begin
            seen = 1;
            break;
         end
         if (if8.busy) nbusy++;
         @(negedge clk);
      end
      if (!seen) chk("timeout8", 64'(seen), 64'd1);
   endtask

   logic [7:0] t_a [6] = '{8'h35, 8'h12, 8'h00, 8'h80, 8'h7F, 8'h5A};
   logic [7:0] t_b [6] = '{8'h12, 8'h35, 8'h01, 8'h01, 8'hFF, 8'h5A};
   logic [7:0] t_d [6] = '{8'h23, 8'hDD, 8'hFF, 8'h7F, 8'h80, 8'h00};
   bit         t_bo[6] = '{0, 1, 1, 0, 1, 0};
   bit         t_ov[6] = '{0, 0, 0, 1, 1, 0};

   initial begin
      int   nb;
      bit   seen;
      int   dcyc[$];
      logic [15:0] ra, rb;
      errs = 0; checks = 0; cyc = 0;
      if8.start = 0;  if8.a = '0;  if8.b = '0;
      if16.start = 0; if16.a = '0; if16.b = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_busy", 64'(if8.busy), 64'd0);
      chk("rst_done", 64'(if8.done), 64'd0);
      chk("rst_diff", 64'(if8.diff), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed literal cases pin both the DUT and the model
      for (int i = 0; i < 6; i++) begin
         op8(t_a[i], t_b[i], nb, seen);
         chk($sformatf("lit_busy_cycles_%0d", i), 64'(nb), 64'd8);
         chk($sformatf("lit_diff_%0d", i), 64'(if8.diff), 64'(t_d[i]));
         chk($sformatf("lit_borrow_%0d", i), 64'(if8.borrow_out), 64'(t_bo[i]));
         chk($sformatf("lit_ovf_%0d", i), 64'(if8.overflow), 64'(t_ov[i]));
         chk($sformatf("model_diff_%0d", i), e8_diff, 64'(t_d[i]));
      end

      // Start held high with operands changing every cycle
      @(negedge clk);
      if8.start = 1'b1;
      for (int i = 0; i < 46; i++) begin
         if8.a = 8'($urandom); if8.b = 8'($urandom);
         @(negedge clk);
         if (if8.done) dcyc.push_back(cyc);
      end
      if8.start = 1'b0;
      chk("hs_done_count", 64'(dcyc.size() >= 4), 64'd1);
      for (int i = 1; i < dcyc.size(); i++)
         chk("hs_spacing", 64'(dcyc[i] - dcyc[i-1]), 64'd10);
      repeat (12) @(negedge clk);

      // Asynchronous reset in the middle of SHIFT
      op8(8'h12, 8'h35, nb, seen);
      @(negedge clk);
      if8.a = 8'h35; if8.b = 8'h12; if8.start = 1'b1;
      @(negedge clk);
      if8.start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(if8.busy), 64'd0);
      chk("mid_rst_done", 64'(if8.done), 64'd0);
      chk("mid_rst_diff", 64'(if8.diff), 64'd0);
      chk("mid_rst_borrow", 64'(if8.borrow_out), 64'd0);
      chk("mid_rst_ovf", 64'(if8.overflow), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (if8.done) seen = 1;
      end
      chk("mid_rst_no_done", 64'(seen), 64'd0);
      op8(8'hFF, 8'hFF, nb, seen);
      chk("post_rst_diff", 64'(if8.diff), 64'h00);
      chk("post_rst_borrow", 64'(if8.borrow_out), 64'd0);

      // Randomized sweep on both widths, with corner operands mixed in
      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         case ($urandom_range(0, 7))
            0: rb = ra;
            1: ra = '0;
            2: rb = 16'hFFFF;
            3: begin ra = 16'h8000; rb = 16'h0080; end
            default: ;
         endcase
         @(negedge clk);
         if8.a = ra[7:0]; if8.b = rb[7:0]; if8.start = 1'b1;
         if16.a = ra;     if16.b = rb;     if16.start = 1'b1;
         @(negedge clk);
         if8.start = 1'b0; if16.start = 1'b0;
         if8.a = ~ra[7:0]; if16.a = ~ra;
         seen = 0;
         for (int k = 0; k < 30; k++) begin
            if (if16.done) begin
               seen = 1;
               break;
            end
            @(negedge clk);
         end
         if (!seen) chk("timeout16", 64'(seen), 64'd1);
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned/two's-complement subtractor computing diff = a - b over WIDTH clock cycles, LSB first, using a single one-bit full subtractor and a borrow flip-flop.
- It is the inverse-operation counterpart of the team's adder cells, for area-constrained datapaths where one result every WIDTH+2 cycles is sufficient.
- A start/busy/done handshake sequences each operation; the result is held stable until the next accepted start.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2 to 64.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
- start  input  1  request to begin an operation; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high while an operation is in progress (SHIFT state).
- done  output  1  one-cycle pulse; results are valid from this cycle on.
- diff  output  WIDTH  (a - b) mod 2^WIDTH.
- borrow_out  output  1  final borrow; 1 iff a < b unsigned.
- overflow  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB].

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - busy, done, diff, borrow_out and overflow all 0.
  - Internal shift registers, bit counter and borrow flip-flop all 0.
  - Reset during SHIFT or DONE aborts the operation with no done pulse.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT when start = 1. On that edge:
    - load a_sh <= a, b_sh <= b.
    - latch a_msb <= a[WIDTH-1], b_msb <= b[WIDTH-1].
    - borrow <= 0, cnt <= 0.
  - SHIFT (busy = 1), on each edge:
    - d = a_sh[0] ^ b_sh[0] ^ borrow.
    - borrow <= (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow).
    - res_sh <= {d, res_sh[WIDTH-1:1]}.
    - a_sh and b_sh shift right by 1; cnt <= cnt + 1.
    - When cnt = WIDTH-1 the edge performs the final bit and the state goes to DONE.
  - DONE (done = 1 for exactly one cycle):
    - The diff, borrow_out and overflow registers are updated on the transition edge into DONE.
    - DONE -> IDLE unconditionally on the next edge.
- Latency: start sampled at edge k; the last bit is processed at edge k+WIDTH; done is high in the cycle after edge k+WIDTH. Minimum spacing between accepted starts is WIDTH+2 cycles.
- start while busy or done is ignored and is not queued. Changes to a and b after capture have no effect.
- diff, borrow_out and overflow hold their values through IDLE until the next operation completes. They do not change at an accepted start.
- Counter width is clog2(WIDTH)+1 so that WIDTH = 2^n does not alias.
- Equal operands give diff = 0, borrow_out = 0, overflow = 0.

Decomposition:
- Shared package/header:
  - FSM state encodings ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2.
  - Clog2 helper function, shared with other serial arithmetic blocks.
- Sub-module one_bit_full_subtractor (inputs A, B, Bin; outputs d, bout), built from two half subtractors plus an OR. It is instantiated once in the serial datapath and is the only combinational arithmetic in the block.

Test Plan:
- Basic subtraction (WIDTH=8): a=0x35, b=0x12, pulse start -> busy for 8 cycles; done pulse 9 cycles after the start edge; diff=0x23, borrow_out=0, overflow=0.
- Borrow case: a=0x12, b=0x35 -> diff=0xDD, borrow_out=1, overflow=0. a=0x00, b=0x01 -> diff=0xFF, borrow_out=1, overflow=0.
- Signed overflow: a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1. a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, overflow=1.
- Handshake robustness: hold start high continuously and change a/b every cycle -> only captured operands are used; each done pulse is exactly 1 cycle; accepted starts are spaced exactly WIDTH+2 cycles apart; outputs are stable between done pulses.
- Reset mid-operation: assert rst_n=0 asynchronously at cycle 4 of SHIFT -> busy, done, diff, borrow_out and overflow go to 0 immediately; no done pulse follows; the next start with a=0xFF, b=0xFF gives diff=0x00, borrow_out=0.
- Randomized sweep with WIDTH=8 and WIDTH=16: at least 1000 random pairs checked against a reference model of a - b, with the borrow and signed-overflow flags also checked.
